mgr_stack_up_rx: RTL
====================

// Module: mgr_stack_up_rx
// PURPOSE
//  Manager-side receiver for one PE's upstream stack bus (pe__stu__*).
//  Accepts valid/ready beats, checks SOM/MOM/EOM framing and packet length, buffers beats in a FIFO.
//  Presents repaired, well-framed packets to manager logic.
//  One instance per PE, placed in the manager array's per-PE generate loop.
// PARAMETERS
//  DATA_W      32  width of pe__stu__data (STACK_UP_INTF_DATA)
//  OOB_W       16  width of pe__stu__oob_data
//  TYPE_W      2   width of pe__stu__type
//  DEPTH       8   FIFO entries, power of 2, >=4
//  MAX_PKT_LEN 16  max beats per packet, SOM..EOM inclusive
// PORTS
//  clk                 in   1       system clock
//  reset_poweron       in   1       async, active-high reset
//  pe__stu__valid      in   1       PE beat valid
//  pe__stu__cntl       in   2       framing code: 01 SOM, 00 MOM, 10 EOM, 11 SOM_EOM
//  pe__stu__type       in   TYPE_W  control/data, vector/scalar
//  pe__stu__data       in   DATA_W  payload
//  pe__stu__oob_data   in   OOB_W   out-of-band payload
//  stu__pe__ready      out  1       receiver ready, registered
//  stu__mgr__valid     out  1       FIFO head valid
//  stu__mgr__cntl      out  2       head framing code (repaired)
//  stu__mgr__type      out  TYPE_W  head type
//  stu__mgr__data      out  DATA_W  head payload
//  stu__mgr__oob_data  out  OOB_W   head OOB payload
//  mgr__stu__ready     in   1       manager pops head when valid&ready
//  stu__mgr__frm_err   out  1       sticky framing/length error
//  mgr__stu__err_clr   in   1       clears frm_err; a new error in the same cycle wins
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM=IDLE; ready rises the first clk edge after reset is released.
//  Async reset mid-packet: FIFO and FSM cleared; partial packet is lost.
//  Handshake:
//  - transfer in = valid&ready at the clk edge
//  - ready_next = (count_next < DEPTH-1), so the FIFO never overflows
//  - valid may be asserted with ready low; the beat is held by the PE
//  Latency: a beat accepted at edge N is visible on stu__mgr__* after edge N (show-ahead, no bypass).
//  Push and pop in the same cycle: count unchanged. Pop when empty: ignored.
//  Ready restores one edge after space reaches 2 free.
//  FSM (input side), len = beats in current packet:
//  - IDLE:
//    - SOM: write, len=1 -> INPKT
//    - SOM_EOM: write -> IDLE
//    - MOM/EOM: drop, set err
//  - INPKT:
//    - MOM: write, len++
//    - EOM: write -> IDLE
//    - SOM/SOM_EOM: write beat with cntl forced EOM, set err -> DROP
//    - len==MAX_PKT_LEN-1 and beat!=EOM: write as EOM, set err -> DROP
//  - DROP:
//    - MOM: drop
//    - EOM: drop -> IDLE
//    - SOM: write -> INPKT
//    - SOM_EOM: write -> IDLE
//  Dropped beats still complete the handshake (ready honoured); a dropped beat consumes no FIFO space.
//  type/data/oob are passed through unmodified. Only cntl is rewritten.
// CONFIGURATION
//  MGR_STU_RX_STATS_EN defined: adds outputs
//  - stu__mgr__pkt_cnt[15:0]: EOM/SOM_EOM beats written
//  - stu__mgr__drop_cnt[15:0]: beats dropped
//  - both counters saturate at 16'hFFFF and reset to 0
//  MGR_STU_RX_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared stack-interface definitions file: cntl codes (SOM/MOM/EOM/SOM_EOM), type codes, DATA/OOB widths.
//  Sub-module mgr_stu_rx_fifo: sync show-ahead FIFO exposing count, push, pop.
//  Top level holds the FSM, length counter, ready register, error flag, and optional stats.
// TESTING
//  T1 SOM,MOM,MOM,EOM with mgr ready=1: four beats out in order, one cycle latency, frm_err=0, pkt_cnt=1.
//  T2 mgr ready=0, PE streams 10 MOM-framed beats, DEPTH=8: ready drops when count reaches 7. No loss.
//     Resume pop: all beats out in order.
//  T3 MOM in IDLE, then SOM_EOM: first beat dropped, err=1, drop_cnt=1. SOM_EOM forwarded.
//  T4 SOM,MOM,SOM,MOM,EOM: out SOM,MOM,EOM(3rd beat rewritten). 4th dropped. 5th dropped -> IDLE. err=1.
//  T5 SOM + 20 MOM, MAX_PKT_LEN=16: 16th beat out as EOM; beats 17..21 dropped until next SOM.
//  T6 assert reset_poweron mid-packet with 3 beats queued: valid/ready/err=0 async.
//     After release: clean SOM_EOM passes.

Source files
------------

// File: rtl/mgr_stack_up_rx_pkg.sv
// Shared stack-up interface definitions for the manager-side receiver.
// Holds the framing (cntl) codes, type codes, default bus widths and the receiver FSM states.
package mgr_stack_up_rx_pkg;

  localparam int unsigned StackUpDataW = 32;
  localparam int unsigned StackUpOobW  = 16;
  localparam int unsigned StackUpTypeW = 2;
  localparam int unsigned StackUpCntlW = 2;

  // Framing codes carried on the cntl field.
  typedef enum logic [1:0] {
    CntlMom    = 2'b00,
    CntlSom    = 2'b01,
    CntlEom    = 2'b10,
    CntlSomEom = 2'b11
  } stu_cntl_e;

  // Type codes: bit 1 selects data/control, bit 0 selects vector/scalar.
  typedef enum logic [1:0] {
    TypeCtrlScalar = 2'b00,
    TypeCtrlVector = 2'b01,
    TypeDataScalar = 2'b10,
    TypeDataVector = 2'b11
  } stu_type_e;

  // Input-side framing FSM.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StInPkt = 2'b01,
    StDrop  = 2'b10
  } rx_state_e;

  // True for any code that closes a packet.
  function automatic logic is_eom(stu_cntl_e c);
    return (c == CntlEom) || (c == CntlSomEom);
  endfunction

endpackage

// File: rtl/mgr_stu_rx_fifo.sv
// Synchronous show-ahead FIFO. The head entry is presented on rdata_o whenever valid_o is high;
// a pop advances to the next entry at the following clock edge. There is no write-to-read bypass,
// so a pushed entry is visible one edge after the push.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset (clears contents and pointers)
//   push_i, wdata_i   write an entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   rdata_o, valid_o  head entry and its valid flag
//   count_o           number of stored entries
module mgr_stu_rx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CntW'(Depth));
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/mgr_stack_up_rx.sv
// Manager-side receiver for one PE's upstream stack bus. Accepts valid/ready beats, checks
// SOM/MOM/EOM framing and packet length, repairs broken packets by rewriting cntl to EOM,
// drops orphan beats, and buffers written beats in a show-ahead FIFO for manager logic.
// Ports:
//   clk, reset_poweron         clock, asynchronous active-high reset
//   pe__stu__*                 PE-side beat (valid, cntl, type, data, oob_data)
//   stu__pe__ready             registered ready back to the PE
//   stu__mgr__*                FIFO head (valid, repaired cntl, type, data, oob_data)
//   mgr__stu__ready            manager pops the head when valid & ready
//   stu__mgr__frm_err          sticky framing/length error
//   mgr__stu__err_clr          clears frm_err (a simultaneous new error wins)
// Optional build macro MGR_STU_RX_STATS_EN adds stu__mgr__pkt_cnt and stu__mgr__drop_cnt,
// 16-bit saturating counters of packet-closing beats written and of beats dropped.
module mgr_stack_up_rx
  import mgr_stack_up_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = StackUpDataW,
  parameter int unsigned OOB_W       = StackUpOobW,
  parameter int unsigned TYPE_W      = StackUpTypeW,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              pe__stu__valid,
  input  logic [1:0]        pe__stu__cntl,
  input  logic [TYPE_W-1:0] pe__stu__type,
  input  logic [DATA_W-1:0] pe__stu__data,
  input  logic [OOB_W-1:0]  pe__stu__oob_data,
  output logic              stu__pe__ready,
  output logic              stu__mgr__valid,
  output logic [1:0]        stu__mgr__cntl,
  output logic [TYPE_W-1:0] stu__mgr__type,
  output logic [DATA_W-1:0] stu__mgr__data,
  output logic [OOB_W-1:0]  stu__mgr__oob_data,
  input  logic              mgr__stu__ready,
  output logic              stu__mgr__frm_err,
`ifdef MGR_STU_RX_STATS_EN
  output logic [15:0]       stu__mgr__pkt_cnt,
  output logic [15:0]       stu__mgr__drop_cnt,
`endif
  input  logic              mgr__stu__err_clr
);

  localparam int unsigned EntryW = StackUpCntlW + TYPE_W + DATA_W + OOB_W;
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned LenW   = $clog2(MAX_PKT_LEN) + 1;
  localparam logic [LenW-1:0] LenLast = LenW'(MAX_PKT_LEN - 1);

  rx_state_e       state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  stu_cntl_e       in_cntl, wr_cntl;
  logic            xfer, beat_write, beat_drop, err_set;

  logic              fifo_push, fifo_pop, fifo_valid;
  logic [EntryW-1:0] fifo_rdata;
  logic [CntW-1:0]   fifo_count, count_nxt;

  assign in_cntl = stu_cntl_e'(pe__stu__cntl);
  assign xfer    = pe__stu__valid && ready_q;

  // Framing FSM: decides per accepted beat whether it is written (and with which cntl) or dropped.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_write = 1'b0;
    beat_drop  = 1'b0;
    err_set    = 1'b0;
    wr_cntl    = in_cntl;
    if (xfer) begin
      case (state_q)
        StIdle: begin
          case (in_cntl)
            CntlSom: begin
              beat_write = 1'b1;
              len_d      = LenW'(1);
              state_d    = StInPkt;
            end
            CntlSomEom: beat_write = 1'b1;
            default: begin
              beat_drop = 1'b1;
              err_set   = 1'b1;
            end
          endcase
        end
        StInPkt: begin
          beat_write = 1'b1;
          if (in_cntl == CntlEom) begin
            state_d = StIdle;
          end else if ((in_cntl == CntlMom) && (len_q != LenLast)) begin
            len_d = len_q + 1'b1;
          end else begin
            // Unexpected SOM or over-long packet: close the packet here and resync on next SOM.
            wr_cntl = CntlEom;
            err_set = 1'b1;
            state_d = StDrop;
          end
        end
        StDrop: begin
          case (in_cntl)
            CntlMom: beat_drop = 1'b1;
            CntlEom: begin
              beat_drop = 1'b1;
              state_d   = StIdle;
            end
            CntlSom: begin
              beat_write = 1'b1;
              len_d      = LenW'(1);
              state_d    = StInPkt;
            end
            default: begin
              beat_write = 1'b1;
              state_d    = StIdle;
            end
          endcase
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign fifo_push = beat_write;
  assign fifo_pop  = mgr__stu__ready && fifo_valid;

  // Occupancy after this edge; ready is computed from it so the FIFO can never overflow.
  always_comb begin
    count_nxt = fifo_count;
    if (fifo_push && !fifo_pop) begin
      count_nxt = fifo_count + 1'b1;
    end else if (!fifo_push && fifo_pop) begin
      count_nxt = fifo_count - 1'b1;
    end
  end

  assign ready_d = (count_nxt < CntW'(DEPTH - 1));
  assign err_d   = err_set ? 1'b1 : (mgr__stu__err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q <= StIdle;
      len_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  mgr_stu_rx_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset_poweron),
    .push_i  (fifo_push),
    .wdata_i ({wr_cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign stu__pe__ready    = ready_q;
  assign stu__mgr__valid   = fifo_valid;
  assign stu__mgr__frm_err = err_q;
  assign {stu__mgr__cntl, stu__mgr__type, stu__mgr__data, stu__mgr__oob_data} = fifo_rdata;

`ifdef MGR_STU_RX_STATS_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (fifo_push && is_eom(wr_cntl) && (pkt_cnt_q != 16'hFFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (beat_drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign stu__mgr__pkt_cnt  = pkt_cnt_q;
  assign stu__mgr__drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = beat_drop;
`endif

endmodule
